// File: rtl/sys_array_feeder.sv
// Operand store and diagonally skewed stream generator feeding sys_array_wrapper.
// Define FEEDER_ERR_EN to enable the err pulse on rejected writes and starts.
module sys_array_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int INNER_DIM  = 4,
  localparam int MAX_WL    = (ARRAY_W > ARRAY_L) ? ARRAY_W : ARRAY_L,
  localparam int ADDR_W    = ($clog2(MAX_WL * INNER_DIM) > 0) ? $clog2(MAX_WL * INNER_DIM) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          load_params,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          start_comp,
  output logic [ARRAY_W*DATA_WIDTH-1:0] a_out,
  output logic [ARRAY_W-1:0]            a_vld,
  output logic [ARRAY_L*DATA_WIDTH-1:0] b_out,
  output logic [ARRAY_L-1:0]            b_vld,
  output logic                          clear_acc,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int MIN_WL  = (ARRAY_W < ARRAY_L) ? ARRAY_W : ARRAY_L;
  localparam int F       = INNER_DIM + MAX_WL - 1;
  localparam int D       = MIN_WL;
  localparam int CNT_MAX = (F > D) ? F : D;
  localparam int TW      = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
  localparam int ASZ     = ARRAY_W * INNER_DIM;
  localparam int BSZ     = INNER_DIM * ARRAY_L;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state;
  logic [TW-1:0]       t;
  logic [TW-1:0]       ft;
  logic [DATA_WIDTH-1:0] a_mem [0:ASZ-1];
  logic [DATA_WIDTH-1:0] b_mem [0:BSZ-1];

  logic                          a_in_range;
  logic                          b_in_range;
  logic                          wr_ok;
  logic [ARRAY_W*DATA_WIDTH-1:0] a_nd;
  logic [ARRAY_W-1:0]            a_nv;
  logic [ARRAY_L*DATA_WIDTH-1:0] b_nd;
  logic [ARRAY_L-1:0]            b_nv;

  assign a_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(ASZ));
  assign b_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(BSZ));
  assign wr_ok      = reset_n && wr_en && load_params && (state == IDLE) && !start_comp;

  always_ff @(posedge clk) begin
    if (wr_ok && !wr_sel && a_in_range) a_mem[wr_addr] <= wr_data;
    if (wr_ok && wr_sel && b_in_range)  b_mem[wr_addr] <= wr_data;
  end

  // Outputs are registered, so lanes are computed for the step about to be shown.
  always_comb begin
    if (state == FEED) begin
      ft = t + TW'(1);
    end else begin
      ft = {TW{1'b0}};
    end
  end

  for (genvar i = 0; i < ARRAY_W; i++) begin : g_a_lane
    logic [TW:0]       dd;
    logic [ADDR_W-1:0] ra;
    assign dd = {1'b0, ft} - (TW+1)'(i);
    assign ra = ADDR_W'(i * INNER_DIM) + ADDR_W'(dd);
    assign a_nv[i] = (dd < (TW+1)'(INNER_DIM));
    assign a_nd[i*DATA_WIDTH +: DATA_WIDTH] = a_nv[i] ? a_mem[ra] : {DATA_WIDTH{1'b0}};
  end

  for (genvar j = 0; j < ARRAY_L; j++) begin : g_b_lane
    logic [TW:0]       dd;
    logic [ADDR_W-1:0] rb;
    assign dd = {1'b0, ft} - (TW+1)'(j);
    assign rb = ADDR_W'(dd) * ADDR_W'(ARRAY_L) + ADDR_W'(j);
    assign b_nv[j] = (dd < (TW+1)'(INNER_DIM));
    assign b_nd[j*DATA_WIDTH +: DATA_WIDTH] = b_nv[j] ? b_mem[rb] : {DATA_WIDTH{1'b0}};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      t         <= {TW{1'b0}};
      a_out     <= {(ARRAY_W*DATA_WIDTH){1'b0}};
      a_vld     <= {ARRAY_W{1'b0}};
      b_out     <= {(ARRAY_L*DATA_WIDTH){1'b0}};
      b_vld     <= {ARRAY_L{1'b0}};
      clear_acc <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      clear_acc <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_comp) begin
            state     <= CLEAR;
            clear_acc <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          state <= FEED;
          t     <= {TW{1'b0}};
          a_out <= a_nd;
          a_vld <= a_nv;
          b_out <= b_nd;
          b_vld <= b_nv;
        end
        FEED: begin
          if (t == TW'(F - 1)) begin
            state <= DRAIN;
            t     <= {TW{1'b0}};
            a_out <= {(ARRAY_W*DATA_WIDTH){1'b0}};
            a_vld <= {ARRAY_W{1'b0}};
            b_out <= {(ARRAY_L*DATA_WIDTH){1'b0}};
            b_vld <= {ARRAY_L{1'b0}};
          end else begin
            t     <= t + TW'(1);
            a_out <= a_nd;
            a_vld <= a_nv;
            b_out <= b_nd;
            b_vld <= b_nv;
          end
        end
        DRAIN: begin
          if (t == TW'(D - 1)) begin
            state <= IDLE;
            t     <= {TW{1'b0}};
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            t <= t + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          t     <= {TW{1'b0}};
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FEEDER_ERR_EN
  logic bad_range;
  logic bad_busy_wr;
  logic bad_busy_start;

  assign bad_range      = wr_en && load_params && (state == IDLE) && !start_comp &&
                          !(wr_sel ? b_in_range : a_in_range);
  assign bad_busy_wr    = wr_en && load_params && (state != IDLE);
  assign bad_busy_start = start_comp && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      err <= bad_range || bad_busy_wr || bad_busy_start;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// Randomized self-checking bench for sys_array_feeder against a matrix-level timeline model.
module tb_sys_array_feeder;

  logic        clk;
  logic        reset_n;
  logic        load_params;
  logic        wr_en;
  logic        wr_sel;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start_comp;
  logic [31:0] a_out;
  logic [3:0]  a_vld;
  logic [31:0] b_out;
  logic [3:0]  b_vld;
  logic        clear_acc;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ma [4][4];
  logic [7:0]  mb [4][4];
  logic [75:0] obs;

`ifdef FEEDER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  sys_array_feeder dut (
    .clk(clk), .reset_n(reset_n), .load_params(load_params), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .start_comp(start_comp),
    .a_out(a_out), .a_vld(a_vld), .b_out(b_out), .b_vld(b_vld),
    .clear_acc(clear_acc), .busy(busy), .done(done), .err(err)
  );

  assign obs = {err, clear_acc, busy, done, a_vld, b_vld, a_out, b_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs c cycles after the start edge (c=0 or c>13 means idle).
  function automatic logic [75:0] exp_vec(int c, bit e);
    logic [3:0]  av;
    logic [3:0]  bv;
    logic [31:0] ao;
    logic [31:0] bo;
    int tt;
    int d;
    av = 4'd0; bv = 4'd0; ao = 32'd0; bo = 32'd0;
    if (c >= 2 && c <= 8) begin
      tt = c - 2;
      for (int i = 0; i < 4; i++) begin
        d = tt - i;
        if (d >= 0 && d < 4) begin
          av[i] = 1'b1;
          ao[i*8 +: 8] = ma[i][d];
          bv[i] = 1'b1;
          bo[i*8 +: 8] = mb[d][i];
        end
      end
    end
    return {e, (c == 1), (c >= 1 && c <= 12), (c == 13), av, bv, ao, bo};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    wr_sel = sel; wr_addr = addr; wr_data = data; wr_en = 1'b1; load_params = 1'b1;
    step;
    wr_en = 1'b0; load_params = 1'b0;
  endtask

  task automatic load_all;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        do_write(1'b0, 4'(i*4 + k), ma[i][k]);
        do_write(1'b1, 4'(i*4 + k), mb[i][k]);
      end
  endtask

  task automatic start_run;
    start_comp = 1'b1;
    step;
    start_comp = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step;
      checks++;
      if (obs !== 76'd0) begin
        errors++; $display("FAIL reset_hold n=%0d got=%h exp=%h", n, obs, 76'd0);
      end
    end
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step;
      checks++;
      if (obs !== 76'd0) begin
        errors++; $display("FAIL reset_idle n=%0d got=%h exp=%h", n, obs, 76'd0);
      end
    end
  endtask

  task automatic test_basic_skew;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 8'(4*i + k + 1);
        mb[i][k] = 8'(16 + 4*i + k);
      end
    load_all;
    start_run;
    for (int c = 1; c <= 13; c++) begin
      checks++;
      if (obs !== exp_vec(c, 1'b0)) begin
        errors++; $display("FAIL basic c=%0d got=%h exp=%h", c, obs, exp_vec(c, 1'b0));
      end
      if (c == 5) begin
        checks++;
        if (a_out[31:24] !== 8'd13 || b_out[23:16] !== 8'd22) begin
          errors++; $display("FAIL basic_t3 got a3=%0d b2=%0d exp a3=13 b2=22", a_out[31:24], b_out[23:16]);
        end
      end
      if (c < 13) step;
    end
    step;
  endtask

  task automatic test_ignored_start;
    logic [75:0] ev;
    start_run;
    for (int c = 1; c <= 13; c++) begin
      ev = exp_vec(c, ERR_ON && (c == 5 || c == 11));
      checks++;
      if (obs !== ev) begin
        errors++; $display("FAIL ignored c=%0d got=%h exp=%h", c, obs, ev);
      end
      start_comp  = (c == 4);
      wr_en       = (c == 10);
      load_params = (c == 10);
      wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 8'hEE;
      if (c < 13) step;
    end
    step;
    checks++;
    if (obs !== exp_vec(0, 1'b0)) begin
      errors++; $display("FAIL ignored_idle got=%h exp=%h", obs, exp_vec(0, 1'b0));
    end
  endtask

  task automatic test_back_to_back;
    start_run;
    for (int r = 0; r < 2; r++)
      for (int c = 1; c <= 13; c++) begin
        checks++;
        if (obs !== exp_vec(c, 1'b0)) begin
          errors++; $display("FAIL b2b r=%0d c=%0d got=%h exp=%h", r, c, obs, exp_vec(c, 1'b0));
        end
        if (c == 13 && r == 0) start_run;
        else if (c < 13) step;
      end
    step;
  endtask

  task automatic test_start_priority;
    start_comp = 1'b1; load_params = 1'b1; wr_en = 1'b1;
    wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'hAB;
    step;
    start_comp = 1'b0; load_params = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      checks++;
      if (obs !== exp_vec(c, 1'b0)) begin
        errors++; $display("FAIL start_prio c=%0d got=%h exp=%h", c, obs, exp_vec(c, 1'b0));
      end
      if (c < 13) step;
    end
    step;
  endtask

  task automatic test_boundary_writes;
    do_write(1'b0, 4'd15, 8'h5A); ma[3][3] = 8'h5A;
    do_write(1'b1, 4'd15, 8'hA5); mb[3][3] = 8'hA5;
    wr_en = 1'b1; load_params = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h77;
    step;
    wr_en = 1'b0;
    checks++;
    if (obs !== exp_vec(0, 1'b0)) begin
      errors++; $display("FAIL boundary_idle got=%h exp=%h", obs, exp_vec(0, 1'b0));
    end
    start_run;
    for (int c = 1; c <= 13; c++) begin
      checks++;
      if (obs !== exp_vec(c, 1'b0)) begin
        errors++; $display("FAIL boundary c=%0d got=%h exp=%h", c, obs, exp_vec(c, 1'b0));
      end
      if (c < 13) step;
    end
    step;
  endtask

  task automatic test_reset_mid_feed;
    start_run;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (obs !== exp_vec(c, 1'b0)) begin
        errors++; $display("FAIL midrst_pre c=%0d got=%h exp=%h", c, obs, exp_vec(c, 1'b0));
      end
      if (c < 5) step;
    end
    reset_n = 1'b0;
    step;
    reset_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      checks++;
      if (obs !== 76'd0) begin
        errors++; $display("FAIL midrst_quiet n=%0d got=%h exp=%h", n, obs, 76'd0);
      end
      step;
    end
    start_run;
    for (int c = 1; c <= 13; c++) begin
      checks++;
      if (obs !== exp_vec(c, 1'b0)) begin
        errors++; $display("FAIL midrst_rerun c=%0d got=%h exp=%h", c, obs, exp_vec(c, 1'b0));
      end
      if (c < 13) step;
    end
    step;
  endtask

  task automatic test_random;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) begin
          ma[i][k] = 8'($urandom_range(0, 255));
          mb[i][k] = 8'($urandom_range(0, 255));
        end
      load_all;
      start_run;
      for (int c = 1; c <= 13; c++) begin
        checks++;
        if (obs !== exp_vec(c, 1'b0)) begin
          errors++; $display("FAIL random it=%0d c=%0d got=%h exp=%h", it, c, obs, exp_vec(c, 1'b0));
        end
        if (c < 13) step;
      end
      step;
    end
  endtask

  initial begin
    reset_n = 1'b1; load_params = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    wr_addr = 4'd0; wr_data = 8'd0; start_comp = 1'b0;
    #1;
    test_reset;
    test_basic_skew;
    test_ignored_start;
    test_back_to_back;
    test_start_priority;
    test_boundary_writes;
    test_reset_mid_feed;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
